tick_gen_multi: RTL and testbench

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

---
 rtl/tick_gen_pkg.sv | 20 ++
 rtl/tick_gen_ch.sv | 130 +++++++++++++
 rtl/tick_gen_multi.sv | 58 +++++
 tb/tb_tick_gen_multi.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared state type and default sizing for the tick generator.
// Consumed by tick_gen_ch and tick_gen_multi.
package tick_gen_pkg;

   localparam int TG_NUM_CH   = 4;
   localparam int TG_CNT_W    = 16;
   localparam int TG_DIV_INIT = 100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_e;

   // Channel-select width, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one tick channel with counter, active/pending divisor and run FSM.
// One-shot mode (DONE state) is compiled in with TICK_GEN_ONESHOT_EN.
module tick_gen_ch
   import tick_gen_pkg::*;
#(
   parameter int CNT_W    = TG_CNT_W,
   parameter int DIV_INIT = TG_DIV_INIT
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
`ifdef TICK_GEN_ONESHOT_EN
   input  logic             oneshot,
`endif
   input  logic             sync_clr,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_val,
   output logic             tick,
   output logic             pend
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] div_pnd_q, div_pnd_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             last;
   logic             last_idle;
   logic             wrap;
   logic             apply;
   logic             go_done;

   assign last      = (cnt_q == div_act_q - CNT_W'(1));
   assign last_idle = (div_act_q == CNT_W'(1));

`ifdef TICK_GEN_ONESHOT_EN
   assign go_done = oneshot;
`else
   assign go_done = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tick_d    = 1'b0;
      div_act_d = div_act_q;
      div_pnd_d = div_pnd_q;
      pend_d    = pend_q;
      wrap      = 1'b0;
      apply     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (en) begin
               if (last_idle) begin
                  tick_d  = 1'b1;
                  state_d = go_done ? ST_DONE : ST_RUN;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            // Disable beats clear, which beats a wrap.
            if (!en) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (sync_clr) begin
               cnt_d = '0;
            end else if (last) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               wrap   = 1'b1;
               if (go_done) state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            cnt_d = '0;
            if (!en) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      apply = wrap | sync_clr | (state_q == ST_IDLE);

      // A write at an apply point lands in div_act; the wrap used the old one.
      if (wr) begin
         div_pnd_d = wr_val;
         if (apply) begin
            div_act_d = wr_val;
            pend_d    = 1'b0;
         end else begin
            pend_d = 1'b1;
         end
      end else if (pend_q && apply) begin
         div_act_d = div_pnd_q;
         pend_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         div_act_q <= CNT_W'(DIV_INIT);
         div_pnd_q <= CNT_W'(DIV_INIT);
         pend_q    <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_act_q <= div_act_d;
         div_pnd_q <= div_pnd_d;
         pend_q    <= pend_d;
         tick_q    <= tick_d;
      end
   end

   assign tick = tick_q;
   assign pend = pend_q;

endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent programmable tick channels sharing one clock.
// Define TICK_GEN_ONESHOT_EN to add the per-channel oneshot input.
module tick_gen_multi
   import tick_gen_pkg::*;
#(
   parameter int  NUM_CH   = TG_NUM_CH,
   parameter int  CNT_W    = TG_CNT_W,
   parameter int  DIV_INIT = TG_DIV_INIT,
   localparam int SEL_W    = sel_width(NUM_CH)
) (
   input  logic              clk_in,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
`ifdef TICK_GEN_ONESHOT_EN
   input  logic [NUM_CH-1:0] oneshot,
`endif
   input  logic              sync_clr,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_val,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] pend
);

   logic [CNT_W-1:0]  wr_val;
   logic [NUM_CH-1:0] wr_ch;

   // A zero divisor would never wrap; treat it as divide-by-one.
   assign wr_val = (div_val == '0) ? CNT_W'(1) : div_val;

   // Out-of-range selects match no channel and are dropped.
   always_comb begin
      wr_ch = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ch[i] = div_wr && (div_sel == SEL_W'(i));
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_gen_ch #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_ch (
         .clk_in   (clk_in),
         .rst      (rst),
         .en       (en[g]),
`ifdef TICK_GEN_ONESHOT_EN
         .oneshot  (oneshot[g]),
`endif
         .sync_clr (sync_clr),
         .wr       (wr_ch[g]),
         .wr_val   (wr_val),
         .tick     (tick[g]),
         .pend     (pend[g])
      );
   end

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: vector table plus scoreboard bench for tick_gen_multi.
// Five channels so that an out-of-range div_sel is reachable.
module tb_tick_gen_multi;

   localparam int NCH = 5;
   localparam int CW  = 16;

   logic           clk_in = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] en = '0;
`ifdef TICK_GEN_ONESHOT_EN
   logic [NCH-1:0] oneshot = '0;
`endif
   logic           sync_clr = 1'b0;
   logic           div_wr = 1'b0;
   logic [2:0]     div_sel = '0;
   logic [CW-1:0]  div_val = '0;
   logic [NCH-1:0] tick;
   logic [NCH-1:0] pend;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string      nm;
      bit         r;
      logic [4:0] en;
      logic [4:0] os;
      bit         c;
      bit         wr;
      logic [2:0] sel;
      logic [15:0] val;
      int         w;
      logic [4:0] quiet;
      logic [4:0] tm;
      logic [4:0] tk;
      logic [4:0] pm;
      logic [4:0] pd;
   } vec_t;

   typedef struct {
      string      nm;
      logic [4:0] tm;
      logic [4:0] tk;
      logic [4:0] pm;
      logic [4:0] pd;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   tick_gen_multi #(
      .NUM_CH   (NCH),
      .CNT_W    (CW),
      .DIV_INIT (100)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
`ifdef TICK_GEN_ONESHOT_EN
      .oneshot  (oneshot),
`endif
      .sync_clr (sync_clr),
      .div_wr   (div_wr),
      .div_sel  (div_sel),
      .div_val  (div_val),
      .tick     (tick),
      .pend     (pend)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(
      input string nm, input bit r, input logic [4:0] e,
      input logic [4:0] os, input bit c, input bit wr,
      input logic [2:0] sel, input logic [15:0] val, input int w,
      input logic [4:0] quiet, input logic [4:0] tm, input logic [4:0] tk,
      input logic [4:0] pm, input logic [4:0] pd);
      vec_t v;
      v.nm = nm; v.r = r; v.en = e; v.os = os; v.c = c; v.wr = wr;
      v.sel = sel; v.val = val; v.w = w; v.quiet = quiet;
      v.tm = tm; v.tk = tk; v.pm = pm; v.pd = pd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [4:0] act,
                      input logic [4:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, act, exp_v);
      end
   endtask

   task automatic compare_exp();
      exp_t e;
      if (sb.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL scoreboard: got empty want entry");
         return;
      end
      e = sb.pop_front();
      if (e.tm != 0) chk({e.nm, "_tick"}, tick & e.tm, e.tk & e.tm);
      if (e.pm != 0) chk({e.nm, "_pend"}, pend & e.pm, e.pd & e.pm);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = '0;
      sync_clr = 1'b0;
      div_wr = 1'b0;
      div_sel = '0;
      div_val = '0;
`ifdef TICK_GEN_ONESHOT_EN
      oneshot = '0;
`endif
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      logic [4:0] seen;
      if (v.r) do_reset();
      en = v.en;
      sync_clr = v.c;
      div_wr = v.wr;
      div_sel = v.sel;
      div_val = v.val;
`ifdef TICK_GEN_ONESHOT_EN
      oneshot = v.os;
`endif
      sb.push_back('{nm: v.nm, tm: v.tm, tk: v.tk, pm: v.pm, pd: v.pd});
      seen = '0;
      for (int k = 1; k <= v.w; k++) begin
         @(posedge clk_in);
         #1;
         sync_clr = 1'b0;
         div_wr = 1'b0;
         if (k < v.w) seen = seen | (tick & v.quiet);
      end
      if (v.quiet != 0 && v.w > 1) chk({v.nm, "_quiet"}, seen, 5'b0);
      compare_exp();
   endtask

   initial begin
      // Divide-by-100 from reset, ticks at 100/200/300.
      tbl.push_back(mk("a_c99",  1, 5'b00001, 0, 0, 0, 0, 0, 99,
                       5'b00001, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("a_c100", 0, 5'b00001, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b11111, 5'b00001, 5'b11111, 5'b00000));
      tbl.push_back(mk("a_c101", 0, 5'b00001, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("a_c200", 0, 5'b00001, 0, 0, 0, 0, 0, 99,
                       5'b00001, 5'b11111, 5'b00001, 5'b00000, 5'b00000));
      tbl.push_back(mk("a_c300", 0, 5'b00001, 0, 0, 0, 0, 0, 100,
                       5'b00001, 5'b11111, 5'b00001, 5'b00000, 5'b00000));
      tbl.push_back(mk("a_c301", 0, 5'b00001, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b00000, 5'b00000));
      // Pending divisor applied at the next wrap.
      tbl.push_back(mk("b_wr10", 1, 5'b00000, 0, 0, 1, 1, 10, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("b_start", 0, 5'b00010, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b00010, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("b_cnt3", 0, 5'b00010, 0, 0, 0, 0, 0, 2,
                       5'b00010, 5'b00010, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("b_wr4", 0, 5'b00010, 0, 0, 1, 1, 4, 1,
                       5'b00000, 5'b00010, 5'b00000, 5'b11111, 5'b00010));
      tbl.push_back(mk("b_c9", 0, 5'b00010, 0, 0, 0, 0, 0, 5,
                       5'b00010, 5'b00010, 5'b00000, 5'b11111, 5'b00010));
      tbl.push_back(mk("b_c10", 0, 5'b00010, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b00010, 5'b00010, 5'b11111, 5'b00000));
      tbl.push_back(mk("b_c14", 0, 5'b00010, 0, 0, 0, 0, 0, 4,
                       5'b00010, 5'b00010, 5'b00010, 5'b11111, 5'b00000));
      tbl.push_back(mk("b_c18", 0, 5'b00010, 0, 0, 0, 0, 0, 4,
                       5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000));
      // Zero divisor becomes one; out-of-range selects are ignored.
      tbl.push_back(mk("c_wr0", 1, 5'b00000, 0, 0, 1, 2, 0, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("c_run1", 0, 5'b11111, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b11111, 5'b00100, 5'b11111, 5'b00000));
      tbl.push_back(mk("c_run2", 0, 5'b11111, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b11111, 5'b00100, 5'b00000, 5'b00000));
      tbl.push_back(mk("c_bad5", 0, 5'b11111, 0, 0, 1, 5, 3, 1,
                       5'b00000, 5'b11111, 5'b00100, 5'b11111, 5'b00000));
      tbl.push_back(mk("c_bad7", 0, 5'b11111, 0, 0, 1, 7, 2, 1,
                       5'b00000, 5'b11111, 5'b00100, 5'b11111, 5'b00000));
      tbl.push_back(mk("c_run14", 0, 5'b11111, 0, 0, 0, 0, 0, 10,
                       5'b11011, 5'b11111, 5'b00100, 5'b11111, 5'b00000));
      // sync_clr realigns div 8 and div 12, then suppresses a wrap.
      tbl.push_back(mk("d_wr8", 1, 5'b00000, 0, 0, 1, 0, 8, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("d_wr12", 0, 5'b00000, 0, 0, 1, 1, 12, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("d_ch0", 0, 5'b00001, 0, 0, 0, 0, 0, 3,
                       5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("d_ch1", 0, 5'b00011, 0, 0, 0, 0, 0, 5,
                       5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("d_clr", 0, 5'b00011, 0, 1, 0, 0, 0, 1,
                       5'b00000, 5'b00011, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s7", 0, 5'b00011, 0, 0, 0, 0, 0, 7,
                       5'b00011, 5'b00011, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s8", 0, 5'b00011, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b00011, 5'b00001, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s11", 0, 5'b00011, 0, 0, 0, 0, 0, 3,
                       5'b00011, 5'b00011, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s12", 0, 5'b00011, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b00011, 5'b00010, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s16", 0, 5'b00011, 0, 0, 0, 0, 0, 4,
                       5'b00011, 5'b00011, 5'b00001, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s24", 0, 5'b00011, 0, 0, 0, 0, 0, 8,
                       5'b00011, 5'b00011, 5'b00011, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s31", 0, 5'b00011, 0, 0, 0, 0, 0, 7,
                       5'b00011, 5'b00011, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_clrwrap", 0, 5'b00011, 0, 1, 0, 0, 0, 1,
                       5'b00000, 5'b00011, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("d_s40", 0, 5'b00011, 0, 0, 0, 0, 0, 8,
                       5'b00011, 5'b00011, 5'b00001, 5'b00000, 5'b00000));
      // Last write wins, write at wrap, disable overrides wrap.
      tbl.push_back(mk("g_wr6", 1, 5'b00000, 0, 0, 1, 3, 6, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("g_start", 0, 5'b01000, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b01000, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("g_wr9", 0, 5'b01000, 0, 0, 1, 3, 9, 1,
                       5'b00000, 5'b01000, 5'b00000, 5'b11111, 5'b01000));
      tbl.push_back(mk("g_wr3", 0, 5'b01000, 0, 0, 1, 3, 3, 1,
                       5'b00000, 5'b01000, 5'b00000, 5'b11111, 5'b01000));
      tbl.push_back(mk("g_c5", 0, 5'b01000, 0, 0, 0, 0, 0, 2,
                       5'b01000, 5'b01000, 5'b00000, 5'b11111, 5'b01000));
      tbl.push_back(mk("g_c6", 0, 5'b01000, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b01000, 5'b01000, 5'b11111, 5'b00000));
      tbl.push_back(mk("g_c9", 0, 5'b01000, 0, 0, 0, 0, 0, 3,
                       5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000));
      tbl.push_back(mk("g_c11", 0, 5'b01000, 0, 0, 0, 0, 0, 2,
                       5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("g_wrapwr", 0, 5'b01000, 0, 0, 1, 3, 5, 1,
                       5'b00000, 5'b01000, 5'b01000, 5'b11111, 5'b00000));
      tbl.push_back(mk("g_c17", 0, 5'b01000, 0, 0, 0, 0, 0, 5,
                       5'b01000, 5'b01000, 5'b01000, 5'b11111, 5'b00000));
      tbl.push_back(mk("g_c21", 0, 5'b01000, 0, 0, 0, 0, 0, 4,
                       5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("g_endrop", 0, 5'b00000, 0, 0, 0, 0, 0, 1,
                       5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("g_idle", 0, 5'b00000, 0, 0, 0, 0, 0, 3,
                       5'b01000, 5'b01000, 5'b00000, 5'b11111, 5'b00000));
`ifdef TICK_GEN_ONESHOT_EN
      tbl.push_back(mk("f_wr5", 1, 5'b00000, 0, 0, 1, 3, 5, 1,
                       5'b00000, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      tbl.push_back(mk("f_c4", 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 4,
                       5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("f_c5", 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 1,
                       5'b00000, 5'b01000, 5'b01000, 5'b00000, 5'b00000));
      tbl.push_back(mk("f_hold", 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 20,
                       5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("f_off", 0, 5'b00000, 5'b01000, 0, 0, 0, 0, 1,
                       5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
      tbl.push_back(mk("f_rearm", 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 5,
                       5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b00000));
      tbl.push_back(mk("f_hold2", 0, 5'b01000, 5'b01000, 0, 0, 0, 0, 10,
                       5'b01000, 5'b01000, 5'b00000, 5'b00000, 5'b00000));
`endif

      do_reset();
      sb.push_back('{nm: "reset", tm: 5'b11111, tk: 5'b00000,
                     pm: 5'b11111, pd: 5'b00000});
      compare_exp();

      foreach (tbl[i]) run_vec(tbl[i]);

      // Asynchronous reset mid-period with a pending write outstanding.
      do_reset();
      div_wr = 1'b1; div_sel = 3'd2; div_val = 16'd1;
      @(posedge clk_in);
      #1;
      div_wr = 1'b0;
      en = 5'b00101;
      repeat (5) @(posedge clk_in);
      #1;
      div_wr = 1'b1; div_sel = 3'd0; div_val = 16'd20;
      sb.push_back('{nm: "e_pre", tm: 5'b00101, tk: 5'b00100,
                     pm: 5'b00001, pd: 5'b00001});
      @(posedge clk_in);
      #1;
      div_wr = 1'b0;
      compare_exp();
      #2;
      rst = 1'b1;
      en = '0;
      sb.push_back('{nm: "e_rst", tm: 5'b11111, tk: 5'b00000,
                     pm: 5'b11111, pd: 5'b00000});
      #1;
      compare_exp();
      repeat (2) @(posedge clk_in);
      #1;
      rst = 1'b0;
      run_vec(mk("e_c99", 0, 5'b00001, 0, 0, 0, 0, 0, 99,
                 5'b00001, 5'b11111, 5'b00000, 5'b11111, 5'b00000));
      run_vec(mk("e_c100", 0, 5'b00001, 0, 0, 0, 0, 0, 1,
                 5'b00000, 5'b11111, 5'b00001, 5'b11111, 5'b00000));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
